// File: rtl/pl_mdu_if.sv
// ID-stage request and result bundle shared by the pipeline and the multiply/divide unit.
// The pipeline drives the decoded instruction fields and forwarded operands;
// the unit returns its interlock, status and HI/LO read-back.
interface pl_mdu_if;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        id_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic [31:0] hilo_out;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op, func, id_valid, rs_val, rt_val,
        input  stall, busy, hilo_out, hi, lo
    );

    modport slave (
        input  op, func, id_valid, rs_val, rt_val,
        output stall, busy, hilo_out, hi, lo
    );
endinterface

// File: rtl/pl_mdu.sv
// Iterative multiply/divide unit for the pipelined MIPS core.
// Decodes MDU instructions in ID, runs a 32-step shift-add multiply or
// restoring divide on operand magnitudes, fixes signs in a final cycle and
// owns HI/LO. Any MDU instruction reaching ID while busy stalls the front end.
module pl_mdu (
    input  logic    clock,
    input  logic    resetn,
    pl_mdu_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    // Instruction decode (only real instructions with op==0 count)
    logic dec_ok;
    logic dec_mfhi, dec_mthi, dec_mflo, dec_mtlo;
    logic dec_mult, dec_multu, dec_div, dec_divu;
    logic mdu_op, start_op, start_div, start_signed;

    assign dec_ok    = bus.id_valid && (bus.op == 6'd0);
    assign dec_mfhi  = dec_ok && (bus.func == F_MFHI);
    assign dec_mthi  = dec_ok && (bus.func == F_MTHI);
    assign dec_mflo  = dec_ok && (bus.func == F_MFLO);
    assign dec_mtlo  = dec_ok && (bus.func == F_MTLO);
    assign dec_mult  = dec_ok && (bus.func == F_MULT);
    assign dec_multu = dec_ok && (bus.func == F_MULTU);
    assign dec_div   = dec_ok && (bus.func == F_DIV);
    assign dec_divu  = dec_ok && (bus.func == F_DIVU);

    assign mdu_op       = dec_mfhi | dec_mthi | dec_mflo | dec_mtlo |
                          dec_mult | dec_multu | dec_div | dec_divu;
    assign start_op     = dec_mult | dec_multu | dec_div | dec_divu;
    assign start_div    = dec_div | dec_divu;
    assign start_signed = dec_mult | dec_div;

    // Operand magnitudes captured at issue (raw values for the unsigned forms)
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;

    assign rs_neg = start_signed & bus.rs_val[31];
    assign rt_neg = start_signed & bus.rt_val[31];
    assign rs_mag = rs_neg ? (32'd0 - bus.rs_val) : bus.rs_val;
    assign rt_mag = rt_neg ? (32'd0 - bus.rt_val) : bus.rt_val;

    // State: acc_q is the product upper half / partial remainder,
    // q_q is the multiplier-then-product-lower-half / dividend-then-quotient,
    // opnd_q is the multiplicand / divisor.
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] q_q, q_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_rs_q, neg_rs_d;
    logic        neg_rt_q, neg_rt_d;
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        busy;
    assign busy = (state_q != S_IDLE);

    assign bus.busy     = busy;
    assign bus.stall    = mdu_op & busy;
    assign bus.hilo_out = dec_mfhi ? hi_q : lo_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // One iteration of either algorithm plus the sign-corrected final results
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    // Datapath: step arithmetic and the fix-up values written in FIX
    always_comb begin
        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, opnd_q} : 33'd0);
        rem_sh  = {acc_q, q_q[31]};
        diff    = rem_sh - {1'b0, opnd_q};

        prod = {acc_q, q_q};
        if (neg_rs_q ^ neg_rt_q) begin
            prod = 64'd0 - prod;
        end

        quot = q_q;
        if (neg_rs_q ^ neg_rt_q) begin
            quot = 32'd0 - q_q;
        end
        // A zero divisor yields all-ones; the remainder path already leaves rs_val in HI.
        if (opnd_q == 32'd0) begin
            quot = 32'hFFFF_FFFF;
        end

        rem = acc_q;
        if (neg_rs_q) begin
            rem = 32'd0 - acc_q;
        end
    end

    // Sequencer: next-state and register updates for IDLE/RUN/FIX
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        q_d      = q_q;
        opnd_d   = opnd_q;
        neg_rs_d = neg_rs_q;
        neg_rt_d = neg_rt_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_op) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd0;
                    acc_d    = 32'd0;
                    neg_rs_d = rs_neg;
                    neg_rt_d = rt_neg;
                    is_div_d = start_div;
                    q_d      = start_div ? rs_mag : rt_mag;
                    opnd_d   = start_div ? rt_mag : rs_mag;
                end else if (dec_mthi) begin
                    hi_d = bus.rs_val;
                end else if (dec_mtlo) begin
                    lo_d = bus.rs_val;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div_q) begin
                    // Keep the trial subtraction only when it did not borrow.
                    acc_d = diff[32] ? rem_sh[31:0] : diff[31:0];
                    q_d   = {q_q[30:0], ~diff[32]};
                end else begin
                    acc_d = mul_sum[32:1];
                    q_d   = {mul_sum[0], q_q[31:1]};
                end
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = quot;
                    hi_d = rem;
                end else begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight and clears HI/LO
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            q_q      <= 32'd0;
            opnd_q   <= 32'd0;
            neg_rs_q <= 1'b0;
            neg_rt_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            opnd_q   <= opnd_d;
            neg_rs_q <= neg_rs_d;
            neg_rt_q <= neg_rt_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: doc/pl_mdu.md
# pl_mdu

Iterative multiply/divide unit with its own sequencing controller and pipeline interlock for the pipelined MIPS CPU. It sits beside the EXE-stage ALU.

- It decodes MDU instructions from the ID-stage `op`/`func` fields.
- It captures forwarded operands and runs a 32-iteration shift-add or restoring-divide sequence.
- It owns the HI/LO registers.
- It stalls the front end whenever an MDU instruction reaches ID while an operation is still in flight.

## Interface
Parameters:
- none (datapath fixed at 32 bits, 32 iterations)

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- op  in  6  ID-stage opcode
- func  in  6  ID-stage function field
- id_valid  in  1  ID holds a real instruction (not a bubble or flushed slot)
- rs_val  in  32  forwarded rs operand in ID
- rt_val  in  32  forwarded rt operand in ID
- stall  out  1  freeze PC and IF/ID, inject a bubble into EXE
- busy  out  1  an operation is in flight
- hilo_out  out  32  result for mfhi/mflo, fed to the EXE result mux
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
Decode applies only when `op`==0 and `id_valid`=1. `func` values:
- 010000 mfhi
- 010001 mthi
- 010010 mflo
- 010011 mtlo
- 011000 mult
- 011001 multu
- 011010 div
- 011011 divu

`mdu_op` is the OR of all eight decodes.

Outputs:
- `stall` = `mdu_op` & `busy`, combinational.
- `busy` = (state != IDLE).
- `hilo_out` = `hi` if mfhi is decoded, else `lo`, combinational.

FSM states: IDLE, RUN, FIX.

IDLE:
- On mult/multu/div/divu with `stall`=0, at the clock edge:
  - latch |rs| and |rt| (raw values for the unsigned forms);
  - latch the sign flags and the op kind;
  - clear the iteration counter (5 bits) and the partial accumulator;
  - go to RUN.
- mthi/mtlo: write `rs_val` into HI/LO at the edge; remain in IDLE.
- mfhi/mflo: no state change.

RUN:
- One iteration per cycle.
  - Multiply: 64-bit shift-add, 1 multiplier bit per cycle.
  - Divide: restoring division, 1 quotient bit per cycle.
- The counter increments each cycle. After the 32nd iteration (counter==31), go to FIX.

FIX:
- Apply sign correction for the signed forms:
  - product is negated when the operand signs differ;
  - quotient is negated when the signs differ;
  - remainder takes the sign of the dividend.
- Write HI/LO:
  - mult: HI = upper 32 bits, LO = lower 32 bits;
  - div: LO = quotient, HI = remainder.
- Go to IDLE.

Arithmetic corner cases:
- Divide by zero (div or divu): LO=0xFFFFFFFF, HI=rs_val. Latency is the normal latency.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0. The result wraps, with no trap.

Other rules:
- An issued operation is never cancelled. A flush of later instructions does not affect it.
- No overlap: any MDU instruction in ID while `busy`=1 stalls, including mthi/mtlo/mfhi/mflo. HI/LO therefore never have concurrent writers.

## Timing
- Reset (`resetn`=0, asynchronous):
  - state=IDLE, counter=0, HI=LO=0;
  - `busy`=0, `stall`=0, `hilo_out`=0;
  - any operation in progress is aborted.
- Issue edge E0.
  - `busy`=1 from after E0 through E33: 32 RUN cycles plus 1 FIX cycle.
  - HI/LO are updated at E33 and `busy` falls at E33.
  - Total latency is 33 cycles.
- mfhi/mflo immediately after mult/div:
  - enters ID in the cycle after E0;
  - stalls for 33 cycles;
  - proceeds in the cycle after E33 with `hilo_out` equal to the new value.
- Back-to-back mult, mult: the second one stalls 33 cycles, then issues at the edge where its `stall` is 0. It cannot issue in the same cycle FIX completes, because `busy`=1 during FIX.
- Non-MDU instructions never stall on `busy`. Independent instructions flow during RUN.
- mthi/mtlo while IDLE: HI/LO are visible on the next cycle. An mfhi in the following ID cycle sees the written value.
- `id_valid`=0 suppresses decode entirely:
  - no issue, no write;
  - `stall`=0 even while `busy`.

## Test plan
- Signed multiply.
  - Stimulus: mult with rs=0xFFFFFFFD (-3), rt=7.
  - Required: 33 cycles later HI=0xFFFFFFFF, LO=0xFFFFFFEB. A multu of the same operands gives HI=0x00000006, LO=0xFFFFFFEB.
- Divide sign and unsigned forms.
  - div -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 100/7 → LO=14, HI=2.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero.
  - divu 0x12345678/0 → LO=0xFFFFFFFF, HI=0x12345678.
  - `busy` deasserts at exactly E33.
- Interlock.
  - Stimulus: mult 3×5 followed immediately by mflo in ID.
  - Required: `stall`=1 for exactly 33 cycles, then `hilo_out`=15.
  - An add placed between the two does not stall.
- Move and bubble.
  - mthi 0xCAFEBABE, then mfhi → `hilo_out`=0xCAFEBABE with no stall.
  - An mtlo with `id_valid`=0 leaves LO unchanged.
- Reset mid-operation.
  - Stimulus: assert `resetn`=0 during RUN (counter≈10), asynchronously to the clock.
  - Required: `busy`, `stall`, HI, LO and `hilo_out` go to 0 immediately.
  - After release, a new mult 2×2 completes normally with LO=4.
